// File: rtl/ccff_ctrl_pkg.sv
// Shared types for the configuration flip-flop chain controller.
package ccff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    LOAD   = 2'd2,
    FINISH = 2'd3
  } ccff_state_t;

endpackage

// File: rtl/ccff_chain_ctrl_if.sv
// Bitstream word handshake between a word source and the chain controller.
interface ccff_chain_ctrl_if #(
  parameter int WORD_W = 8
);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;

  modport master (output word_valid, word_data, input word_ready);
  modport slave  (input word_valid, word_data, output word_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// Turns accepted bitstream words into one bit per cycle, LSB first.
// Stops requesting once the buffered bits cover everything still to be shifted.
module ccff_word_serializer #(
  parameter int WORD_W = 8,
  parameter int REM_W  = 7
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              active,
  input  logic [REM_W-1:0]  remaining,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              bit_en,
  output logic              bit_out
);
  localparam int VW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shreg;
  logic [VW-1:0]     vcnt;
  logic              take;

  always_comb begin
    bit_en     = active && (vcnt != '0) && (remaining != '0);
    bit_out    = bit_en & shreg[0];
    // Refill either into an empty buffer or in the cycle its last bit leaves.
    word_ready = active && ((vcnt == '0) || ((vcnt == VW'(1)) && bit_en))
                 && (32'(remaining) > 32'(vcnt));
    take       = word_valid & word_ready;
  end

  always_ff @(posedge CK) begin
    if (RST || !active) begin
      shreg <= '0;
      vcnt  <= '0;
    end else if (take) begin
      shreg <= word_data;
      vcnt  <= VW'(WORD_W);
    end else if (bit_en) begin
      shreg <= shreg >> 1;
      vcnt  <= vcnt - VW'(1);
    end
  end

endmodule

// File: rtl/ccff_chain_ctrl.sv
// Programs a configuration flip-flop chain: one clear/preset cycle, then
// exactly CHAIN_LEN shifted bitstream bits, then a one-cycle done pulse.
module ccff_chain_ctrl
  import ccff_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               start,
  input  logic               preset_mode,
  ccff_chain_ctrl_if.slave   bs,
  output logic               chain_rst,
  output logic               chain_set,
  output logic               chain_en,
  output logic               chain_head,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(CHAIN_LEN + 1);

  ccff_state_t   state, state_nxt;
  logic          mode;
  logic [CW-1:0] cnt;
  logic [CW-1:0] remaining;
  logic          in_load;

  always_ff @(posedge CK) begin
    if (RST) begin
      state <= IDLE;
      mode  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) mode <= preset_mode;
      if (state == INIT || state == IDLE) cnt <= '0;
      else if (chain_en)                  cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    chain_rst = 1'b0;
    chain_set = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    in_load   = (state == LOAD);
    remaining = CW'(CHAIN_LEN) - cnt;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT: begin
        chain_rst = ~mode;
        chain_set = mode;
        state_nxt = LOAD;
      end
      LOAD:    if (chain_en && cnt == CW'(CHAIN_LEN - 1)) state_nxt = FINISH;
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .REM_W  (CW)
  ) u_ser (
    .CK         (CK),
    .RST        (RST),
    .active     (in_load),
    .remaining  (remaining),
    .word_valid (bs.word_valid),
    .word_data  (bs.word_data),
    .word_ready (bs.word_ready),
    .bit_en     (chain_en),
    .bit_out    (chain_head)
  );

endmodule

// File: tb/tb_ccff_chain_ctrl.sv
// Randomized bench for ccff_chain_ctrl: three chain lengths (16, 10, 1) checked
// against a bit-list model derived from the offered words.
module tb_ccff_chain_ctrl;
  localparam int NDUT = 3;

  logic CK = 1'b0;
  logic RST;
  always #5 CK = ~CK;

  logic [NDUT-1:0] start, mode, valid;
  logic [7:0]      data [NDUT];
  logic [NDUT-1:0] ready, crst, cset, cen, chead, busy, done;

  int checks = 0;
  int errors = 0;
  logic [7:0] wq[$];

  ccff_chain_ctrl_if #(.WORD_W(8)) bs0 ();
  ccff_chain_ctrl_if #(.WORD_W(8)) bs1 ();
  ccff_chain_ctrl_if #(.WORD_W(8)) bs2 ();

  assign bs0.word_valid = valid[0];
  assign bs1.word_valid = valid[1];
  assign bs2.word_valid = valid[2];
  assign bs0.word_data  = data[0];
  assign bs1.word_data  = data[1];
  assign bs2.word_data  = data[2];
  assign ready[0] = bs0.word_ready;
  assign ready[1] = bs1.word_ready;
  assign ready[2] = bs2.word_ready;

  ccff_chain_ctrl #(.CHAIN_LEN(16), .WORD_W(8)) u0 (
    .CK(CK), .RST(RST), .start(start[0]), .preset_mode(mode[0]), .bs(bs0),
    .chain_rst(crst[0]), .chain_set(cset[0]), .chain_en(cen[0]),
    .chain_head(chead[0]), .busy(busy[0]), .done(done[0]));

  ccff_chain_ctrl #(.CHAIN_LEN(10), .WORD_W(8)) u1 (
    .CK(CK), .RST(RST), .start(start[1]), .preset_mode(mode[1]), .bs(bs1),
    .chain_rst(crst[1]), .chain_set(cset[1]), .chain_en(cen[1]),
    .chain_head(chead[1]), .busy(busy[1]), .done(done[1]));

  ccff_chain_ctrl #(.CHAIN_LEN(1), .WORD_W(8)) u2 (
    .CK(CK), .RST(RST), .start(start[2]), .preset_mode(mode[2]), .bs(bs2),
    .chain_rst(crst[2]), .chain_set(cset[2]), .chain_en(cen[2]),
    .chain_head(chead[2]), .busy(busy[2]), .done(done[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int chain_len(input int d);
    case (d)
      0:       return 16;
      1:       return 10;
      default: return 1;
    endcase
  endfunction

  // One programming run on DUT d. wq holds the words to offer; expected heads
  // are their bits LSB first, truncated to the chain length.
  task automatic run(input int d, input bit m, input int stall_pct, input int forced_gaps,
                     input int abort_after, input bit poke_start);
    int len, nwords, n_en, first_en, last_en, n_rst, n_set, n_both;
    int done_cnt, done_cyc, acc, refusals, head_viol, ready_bad, busy_bad, gaps_left, span;
    bit exp_bits[$];
    logic [7:0] w;
    bit want, exp_busy;

    len = chain_len(d);
    nwords = (len + 7) / 8;
    wq.push_back(8'($urandom));
    for (int i = 0; i < nwords; i++) begin
      w = wq[i];
      for (int b = 0; b < 8; b++)
        if (exp_bits.size() < len) exp_bits.push_back(w[b]);
    end
    n_en = 0; first_en = -1; last_en = -1; n_rst = 0; n_set = 0; n_both = 0;
    done_cnt = 0; done_cyc = -1; acc = 0; refusals = 0; head_viol = 0;
    ready_bad = 0; busy_bad = 0; gaps_left = forced_gaps;

    @(negedge CK);
    start[d] = 1'b1;
    mode[d]  = m;
    @(negedge CK);
    start[d] = 1'b0;
    mode[d]  = 1'($urandom);

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done_cyc >= 0 && cyc > done_cyc + 3) break;
      n_rst  += int'(crst[d]);
      n_set  += int'(cset[d]);
      n_both += int'(crst[d] & cset[d]);
      if (cen[d]) begin
        if (n_en < len) check($sformatf("head%0d_dut%0d", n_en, d), 32'(chead[d]), 32'(exp_bits[n_en]));
        n_en++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end else if (chead[d] !== 1'b0) head_viol++;
      if ((crst[d] || cset[d] || done[d]) && ready[d]) ready_bad++;
      if (done[d]) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      exp_busy = (done_cyc < 0) || (cyc == done_cyc);
      if (busy[d] !== exp_busy) busy_bad++;

      if (abort_after > 0 && n_en == abort_after) begin
        valid[d] = 1'b0;
        RST = 1'b1;
        @(negedge CK);
        check("abort_outs", 32'({ready[d], crst[d], cset[d], cen[d], chead[d], busy[d], done[d]}), 32'd0);
        RST = 1'b0;
        busy_bad = 0;
        repeat (3) begin
          @(negedge CK);
          done_cnt += int'(done[d]);
          busy_bad += int'(busy[d]);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle", 32'(busy_bad), 32'd0);
        return;
      end

      start[d] = poke_start && (cyc == 4 || cyc == 12);
      want = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      if (acc > 0 && ready[d] && gaps_left > 0) begin
        want = 1'b0;
        gaps_left--;
      end
      valid[d] = want;
      data[d]  = (acc < wq.size()) ? wq[acc] : 8'($urandom);
      if (ready[d]) begin
        if (want) acc++;
        else if (acc > 0) refusals++;
      end
      @(negedge CK);
    end
    valid[d] = 1'b0;
    start[d] = 1'b0;

    span = (first_en < 0) ? 0 : last_en - first_en + 1;
    check("en_count", 32'(n_en), 32'(len));
    check("words_accepted", 32'(nwords), 32'(acc));
    check(m ? "set_pulse" : "rst_pulse", 32'(m ? n_set : n_rst), 32'd1);
    check(m ? "no_rst_pulse" : "no_set_pulse", 32'(m ? n_rst : n_set), 32'd0);
    check("rst_set_both", 32'(n_both), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_latency", 32'(done_cyc), 32'(last_en + 1));
    check("en_span", 32'(span), 32'(len + refusals));
    check("head_when_idle", 32'(head_viol), 32'd0);
    check("ready_outside_load", 32'(ready_bad), 32'd0);
    check("busy", 32'(busy_bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    start = '0; mode = '0; valid = '0;
    for (int i = 0; i < NDUT; i++) data[i] = '0;
    RST = 1'b1;
    repeat (3) @(negedge CK);
    for (int d = 0; d < NDUT; d++)
      check($sformatf("reset_outs_dut%0d", d),
            32'({ready[d], crst[d], cset[d], cen[d], chead[d], busy[d], done[d]}), 32'd0);
    RST = 1'b0;

    wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h3C);
    run(0, 1'b0, 0, 0, 0, 1'b0);

    wq.delete(); wq.push_back(8'hFF); wq.push_back(8'h02);
    run(1, 1'b1, 0, 0, 0, 1'b0);

    wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h3C);
    run(0, 1'b0, 0, 3, 0, 1'b0);

    wq.delete(); wq.push_back(8'($urandom)); wq.push_back(8'($urandom));
    run(0, 1'b1, 0, 0, 5, 1'b0);
    wq.delete(); wq.push_back(8'($urandom)); wq.push_back(8'($urandom));
    run(0, 1'b0, 0, 0, 0, 1'b0);

    wq.delete(); wq.push_back(8'($urandom)); wq.push_back(8'($urandom));
    run(0, 1'b1, 0, 0, 0, 1'b1);

    wq.delete(); wq.push_back(8'h01);
    run(2, 1'b0, 0, 0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int d;
      d = $urandom_range(NDUT - 1);
      wq.delete();
      for (int i = 0; i < (chain_len(d) + 7) / 8; i++) wq.push_back(8'($urandom));
      run(d, 1'($urandom), 30, 0, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_ctrl.md
CCFF_CHAIN_CTRL -- requirements
Module: ccff_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64, number of configuration flip-flops in the driven chain (>=1).
REQ-002 SHALL have parameter WORD_W, default 8, bitstream word width (>=1).
REQ-003 SHALL have port CK  input  1  rising-edge clock shared with the chain.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to program the chain; ignored unless IDLE.
REQ-006 SHALL have port preset_mode  input  1  sampled with start: 0 = clear chain, 1 = preset chain.
REQ-007 SHALL have port word_valid  input  1  bitstream word offered.
REQ-008 SHALL have port word_data  input  WORD_W  bitstream word, LSB shifted first.
REQ-009 SHALL have port word_ready  output  1  controller accepts word_data this cycle.
REQ-010 SHALL have port chain_rst  output  1  synchronous clear to all chain flip-flops.
REQ-011 SHALL have port chain_set  output  1  synchronous preset to all chain flip-flops.
REQ-012 SHALL have port chain_en  output  1  shift enable to the chain (one bit per asserted cycle).
REQ-013 SHALL have port chain_head  output  1  data into first chain flip-flop, valid when chain_en=1.
REQ-014 SHALL have ports busy and done  output  1 each  busy: not IDLE; done: one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, INIT, LOAD, FINISH.
REQ-016 IDLE->INIT on start=1; preset_mode SHALL be latched that cycle.
REQ-017 INIT SHALL last exactly one cycle, driving chain_rst=1 (mode 0) or chain_set=1 (mode 1), never both; then ->LOAD.
REQ-018 In LOAD, word_ready SHALL be 1 when the internal bit buffer is empty, or when its last valid bit is shifted this cycle, and bits remain to be requested.
REQ-019 Handshake: transfer occurs on word_valid & word_ready; first bit of an accepted word SHALL appear on chain_head with chain_en=1 the next cycle.
REQ-020 Back-to-back words SHALL shift with no bubble cycles; word_valid low SHALL stall shifting (chain_en=0) without loss.
REQ-021 Exactly CHAIN_LEN chain_en pulses SHALL occur per programming run; total words requested = ceil(CHAIN_LEN/WORD_W).
REQ-022 Excess bits of the final word beyond CHAIN_LEN SHALL be discarded, never shifted.
REQ-023 Bit counter width SHALL be clog2(CHAIN_LEN+1); no wrap within a run.
REQ-024 After the CHAIN_LEN-th chain_en cycle, FSM SHALL enter FINISH, assert done=1 for exactly one cycle, then return to IDLE.
REQ-025 start asserted in INIT, LOAD or FINISH SHALL be ignored.
REQ-026 word_ready SHALL be 0 in IDLE, INIT and FINISH.
REQ-027 chain_head SHALL be 0 whenever chain_en=0.

Reset
REQ-028 RST=1 at a rising CK edge SHALL force IDLE, clear bit counter and buffer; outputs word_ready, chain_rst, chain_set, chain_en, chain_head, busy, done SHALL be 0.
REQ-029 RST mid-run SHALL abort without done; partially shifted chain contents are left as-is.
REQ-030 RST SHALL take priority over start in the same cycle.

Structure
REQ-031 FSM state encoding type and state constants SHALL live in shared package ccff_ctrl_pkg.
REQ-032 Word-to-bit serializer (buffer, valid-bit count, ready logic) SHALL be sub-module ccff_word_serializer; FSM and chain counter stay in top.

Verification
REQ-033 CHAIN_LEN=16, WORD_W=8, mode 0, words 0xA5,0x3C streamed continuously -> chain_rst pulse 1 cycle, 16 consecutive chain_en cycles, head sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, done 1 cycle later.
REQ-034 CHAIN_LEN=10, WORD_W=8, mode 1, words 0xFF,0x02 -> chain_set 1 cycle, 10 chain_en pulses, last two heads 0,1, upper 6 bits of 0x02 discarded, only 2 words accepted.
REQ-035 CHAIN_LEN=16, word_valid dropped 3 cycles between words -> chain_en low exactly 3 cycles, bit order unchanged, total 16 pulses.
REQ-036 RST asserted after 5 chain_en pulses -> next cycle all outputs 0, no done; subsequent start runs full 16-bit sequence.
REQ-037 start pulsed during LOAD -> no effect on count, no second INIT pulse; single done.
REQ-038 CHAIN_LEN=1, WORD_W=8, word 0x01 -> one chain_en with head=1, done next cycle, one word accepted.
